// File: rtl/gbfact_pkg.sv
// Shared defaults and types for the activation global-buffer stream controller.
// The optional high-water-mark port is enabled with GBFACT_HWM_EN.
package gbfact_pkg;

    localparam int GBFACT_DEPTH_BIT = 6;
    localparam int GBFACT_WIDTH     = 28;
    localparam int OUTBUF_DEPTH     = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_e;

endpackage

// File: rtl/gbfact_out_buf.sv
// Two-entry registered output FIFO holding words returned by the SRAM.
// Entry 0 is always the head; a pop shifts entry 1 forward.
module gbfact_out_buf
    import gbfact_pkg::*;
#(
    parameter int WIDTH = GBFACT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             rd_ready,
    output logic [1:0]       buf_cnt,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic             pop;

    always_comb begin
        pop   = (cnt_q != 2'd0) && rd_ready;
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = push_data;
                    else               e1_d = push_data;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = push_data;
                    end else begin
                        e0_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign buf_cnt  = cnt_q;
    assign rd_valid = (cnt_q != 2'd0);
    assign rd_data  = e0_q;

endmodule

// File: rtl/gbfact_stream_ctrl.sv
// Ready/valid FIFO front-end for the single-port activation buffer SRAM.
// Define GBFACT_HWM_EN to add the count high-water-mark output hwm.
module gbfact_stream_ctrl
    import gbfact_pkg::*;
#(
    parameter int SRAM_DEPTH_BIT = GBFACT_DEPTH_BIT,
    parameter int SRAM_WIDTH     = GBFACT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [SRAM_WIDTH-1:0]     wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [SRAM_WIDTH-1:0]     rd_data,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_w,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
    output logic                      ram_write_en,
    output logic                      ram_read_en,
    output logic [SRAM_WIDTH-1:0]     ram_data_in,
    input  logic [SRAM_WIDTH-1:0]     ram_data_out,
    output logic [SRAM_DEPTH_BIT:0]   count
`ifdef GBFACT_HWM_EN
    ,
    output logic [SRAM_DEPTH_BIT:0]   hwm
`endif
);

    localparam int AW = SRAM_DEPTH_BIT;
    localparam int CW = SRAM_DEPTH_BIT + 1;

    logic            run_q;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   ram_cnt_q, ram_cnt_d;
    logic            inflight_q, inflight_d;
    logic            rr_q, rr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   addr_w_q, addr_r_q;
    logic [SRAM_WIDTH-1:0] data_in_q;
    logic [1:0]      buf_cnt;
    logic            wr_req, rd_req, pop;
    grant_e          gnt;

    // ram_cnt MSB set means exactly DEPTH words are stored
    assign wr_req = run_q && wr_valid && !ram_cnt_q[AW] && !flush;
    assign rd_req = (ram_cnt_q != '0) && !flush &&
                    ((3'(buf_cnt) + 3'(inflight_q)) < 3'(OUTBUF_DEPTH));

    always_comb begin
        gnt  = GNT_NONE;
        rr_d = rr_q;
        if (wr_req && rd_req) begin
            gnt  = rr_q ? GNT_WR : GNT_RD;
            rr_d = !rr_q;
        end else if (wr_req) begin
            gnt = GNT_WR;
        end else if (rd_req) begin
            gnt = GNT_RD;
        end
        if (flush) rr_d = 1'b0;
    end

    assign wr_ready     = (gnt == GNT_WR);
    assign ram_write_en = (gnt == GNT_WR);
    assign ram_read_en  = (gnt == GNT_RD);
    assign ram_addr_w   = ram_write_en ? wptr_q : addr_w_q;
    assign ram_data_in  = ram_write_en ? wr_data : data_in_q;
    assign ram_addr_r   = ram_read_en ? rptr_q : addr_r_q;
    assign pop          = rd_valid && rd_ready;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = ram_read_en;
        count_d    = count_q + CW'(ram_write_en) - CW'(pop);
        case (gnt)
            GNT_WR: begin
                wptr_d    = wptr_q + AW'(1);
                ram_cnt_d = ram_cnt_q + CW'(1);
            end
            GNT_RD: begin
                rptr_d    = rptr_q + AW'(1);
                ram_cnt_d = ram_cnt_q - CW'(1);
            end
            default: ;
        endcase
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            rr_q       <= 1'b0;
            count_q    <= '0;
            addr_w_q   <= '0;
            addr_r_q   <= '0;
            data_in_q  <= '0;
        end else begin
            run_q      <= 1'b1;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            rr_q       <= rr_d;
            count_q    <= count_d;
            addr_w_q   <= ram_addr_w;
            addr_r_q   <= ram_addr_r;
            data_in_q  <= ram_data_in;
        end
    end

    assign count = count_q;

    gbfact_out_buf #(
        .WIDTH(SRAM_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (inflight_q && !flush),
        .push_data(ram_data_out),
        .rd_ready (rd_ready),
        .buf_cnt  (buf_cnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

`ifdef GBFACT_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = (count_q > hwm_q) ? count_q : hwm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hwm_q <= '0;
        else        hwm_q <= hwm_d;
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_gbfact_stream_ctrl.sv
// Bench for gbfact_stream_ctrl with a behavioural SRAM wrapper and a FIFO scoreboard.
// Build with GBFACT_HWM_EN defined to also exercise the hwm port.
module tb_gbfact_stream_ctrl;

    localparam int AW    = 6;
    localparam int W     = 28;
    localparam int DEPTH = 1 << AW;
    localparam int CAP   = DEPTH + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [W-1:0]  wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [W-1:0]  rd_data;
    logic [AW-1:0] ram_addr_w;
    logic [AW-1:0] ram_addr_r;
    logic          ram_write_en;
    logic          ram_read_en;
    logic [W-1:0]  ram_data_in;
    logic [W-1:0]  ram_data_out;
    logic [AW:0]   count;
`ifdef GBFACT_HWM_EN
    logic [AW:0]   hwm;
`endif

    gbfact_stream_ctrl #(
        .SRAM_DEPTH_BIT(AW),
        .SRAM_WIDTH    (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .ram_addr_w  (ram_addr_w),
        .ram_addr_r  (ram_addr_r),
        .ram_write_en(ram_write_en),
        .ram_read_en (ram_read_en),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .count       (count)
`ifdef GBFACT_HWM_EN
        ,
        .hwm         (hwm)
`endif
    );

    always #5 clk = ~clk;

    // Single-port SRAM wrapper: one-cycle read latency.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
        if (ram_read_en)  ram_data_out <= mem[ram_addr_r];
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] q[$];

    logic          last_acc, last_pop, last_wrr, last_rv;
    logic          last_wen, last_ren;
    logic [W-1:0]  last_rdata;
    logic [AW-1:0] last_addr_w;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluate one clock cycle: inputs were set at the preceding negedge.
    task automatic tick();
        #1;
        last_acc    = wr_valid && wr_ready;
        last_pop    = rd_valid && rd_ready;
        last_wrr    = wr_ready;
        last_rv     = rd_valid;
        last_rdata  = rd_data;
        last_wen    = ram_write_en;
        last_ren    = ram_read_en;
        last_addr_w = ram_addr_w;
        chk("port_excl", 64'(ram_write_en && ram_read_en), 0);
        if (flush) begin
            chk("flush_wr_ready", 64'(wr_ready), 0);
            chk("flush_en", 64'(ram_write_en || ram_read_en), 0);
        end
        if (last_pop) begin
            if (q.size() == 0) chk("pop_empty", 1, 0);
            else chk("rd_data", 64'(rd_data), 64'(q.pop_front()));
        end
        if (flush) q.delete();
        else if (last_acc) q.push_back(wr_data);
        @(posedge clk);
        @(negedge clk);
        chk("count", 64'(count), 64'(q.size()));
    endtask

    initial begin
        int nxt, n_rd;
        logic found, prev_ren;
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr_ready", 64'(wr_ready), 0);
        chk("rst_rd_valid", 64'(rd_valid), 0);
        chk("rst_rd_data", 64'(rd_data), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_en", 64'(ram_write_en || ram_read_en), 0);
`ifdef GBFACT_HWM_EN
        chk("rst_hwm", 64'(hwm), 0);
`endif
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // single word latency
        wr_valid = 1'b1;
        wr_data  = 28'h1234567;
        rd_ready = 1'b1;
        tick();
        chk("sw_acc", 64'(last_acc), 1);
        wr_valid = 1'b0;
        tick();
        chk("sw_rv_t1", 64'(last_rv), 0);
        tick();
        chk("sw_rv_t2", 64'(last_rv), 0);
        tick();
        chk("sw_rv_t3", 64'(last_rv), 1);
        chk("sw_data", 64'(last_rdata), 64'h1234567);
        chk("sw_empty", 64'(count), 0);

        // fill to full with the consumer stalled
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 400 && q.size() < CAP; i++) begin
            wr_data = W'($urandom);
            tick();
        end
        chk("fill_reach", 64'(q.size()), 64'(CAP));
        tick();
        chk("full_wr_ready", 64'(last_wrr), 0);
        chk("full_count", 64'(count), 64'(CAP));
        rd_ready = 1'b1;
        tick();
        chk("full_pop", 64'(last_pop), 1);
        rd_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 && !found; i++) begin
            wr_data = W'($urandom);
            tick();
            found = last_acc;
        end
        chk("full_recover", 64'(found), 1);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 500 && q.size() != 0; i++) tick();
        chk("fill_drained", 64'(q.size()), 0);

        // flush with stored words and a read in flight
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 100 && q.size() < 20; i++) begin
            wr_data = W'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        repeat (4) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        tick();
        chk("flush_rd_issue", 64'(last_ren), 1);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 28'h0BADBAD;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        chk("flush_rd_valid", 64'(rd_valid), 0);
        chk("flush_count", 64'(count), 0);
        wr_valid = 1'b1;
        wr_data  = 28'h0ABCDEF;
        tick();
        chk("post_flush_acc", 64'(last_acc), 1);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = last_pop;
        end
        chk("post_flush_pop", 64'(found), 1);
        chk("post_flush_data", 64'(last_rdata), 64'h0ABCDEF);

        // wrap ordering with random back-pressure
        nxt = 0;
        for (int i = 0; i < 3000 && !(nxt == 200 && q.size() == 0); i++) begin
            wr_valid = (nxt < 200);
            wr_data  = W'(32'h100000 + nxt);
            rd_ready = ($urandom_range(1, 0) == 1);
            tick();
            if (last_acc) nxt++;
        end
        chk("wrap_sent", 64'(nxt), 200);
        chk("wrap_drained", 64'(q.size()), 0);

        // contention: both sides busy with a partly filled RAM
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 100 && q.size() < 20; i++) begin
            wr_data = W'($urandom);
            tick();
        end
        rd_ready = 1'b1;
        prev_ren = 1'b0;
        n_rd = 0;
        for (int i = 0; i < 30; i++) begin
            wr_data = W'($urandom);
            tick();
            chk("cont_one_grant", 64'(int'(last_wen) + int'(last_ren)), 1);
            chk("cont_no_rd_rd", 64'(prev_ren && last_ren), 0);
            prev_ren = last_ren;
            if (last_ren) n_rd++;
        end
        chk("cont_rd_share", 64'(n_rd >= 7), 1);
        wr_valid = 1'b0;
        for (int i = 0; i < 500 && q.size() != 0; i++) tick();
        chk("cont_drained", 64'(q.size()), 0);

        // asynchronous reset mid-operation
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        repeat (5) begin
            wr_data = W'($urandom);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_rd_valid", 64'(rd_valid), 0);
        chk("mid_rst_wr_ready", 64'(wr_ready), 0);
`ifdef GBFACT_HWM_EN
        chk("mid_rst_hwm", 64'(hwm), 0);
`endif
        q.delete();
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 28'h0C0FFEE;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            found = last_acc;
        end
        chk("mid_rst_acc", 64'(found), 1);
        chk("mid_rst_addr0", 64'(last_addr_w), 0);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("mid_rst_drained", 64'(q.size()), 0);

`ifdef GBFACT_HWM_EN
        // high-water mark survives drain and flush, not reset
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 100 && q.size() < 37; i++) begin
            wr_data = W'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        tick();
        chk("hwm_drain", 64'(hwm), 37);
        rd_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("hwm_flush", 64'(hwm), 37);
        #2 rst_n = 1'b0;
        #1;
        chk("hwm_reset", 64'(hwm), 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
